// File: rtl/button_shaper_pkg.sv
// Shared definitions for the button shaper.
// Contents:
//   shaper_state_t          - 2-bit per-channel FSM state encoding
//   DEFAULT_DEBOUNCE_CYCLES - default stable-cycle count to accept a level change
//   DEFAULT_REPEAT_CYCLES   - default autorepeat period (BUTTON_AUTOREPEAT_EN builds only)
//   counter_width()         - width of a counter that can hold max(a, b)
package button_shaper_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_DB   = 2'b01,
    HELD       = 2'b10,
    RELEASE_DB = 2'b11
  } shaper_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_REPEAT_CYCLES   = 25000000;

  // Sized for the larger of the two periods so the same counter can serve
  // both the debounce and the autorepeat timing.
  function automatic int unsigned counter_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_shaper_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and counter.
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a level change
//   REPEAT_CYCLES   - autorepeat period (only used when BUTTON_AUTOREPEAT_EN is defined)
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   raw   - asynchronous key input, active-low (0 = pressed)
//   pulse - registered one-cycle active-high press pulse
// Optional feature: BUTTON_AUTOREPEAT_EN adds repeat pulses while the key is held.
module button_shaper_channel
  import button_shaper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = counter_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       sync;
  logic             pressed;
  shaper_state_t    state;
  logic [CNT_W-1:0] cnt;
`ifdef BUTTON_AUTOREPEAT_EN
  // Set only by an accepted press, so a key held through reset or re-pressed
  // during release debounce never starts repeating on its own.
  logic             armed;
`endif

  // Two-flop synchronizer; reset loads the released level so a held key is
  // seen as a fresh level after reset rather than as a glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  assign pressed = ~sync[1];

  // Debounce FSM. Reset parks in RELEASE_DB so a key still held afterwards
  // lands in HELD without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASE_DB;
      cnt   <= '0;
      pulse <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      armed <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            cnt   <= '0;
            pulse <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            armed <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= RELEASE_DB;
            cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            armed <= 1'b0;
`endif
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (armed) begin
            if (cnt == RPT_LAST) begin
              cnt   <= '0;
              pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif
        end
        RELEASE_DB: begin
          if (pressed) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RELEASE_DB;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_shaper.sv
// Button shaper: turns three bouncy active-low keys into clean one-cycle
// active-high press pulses. The three channels are independent copies.
// Parameters:
//   DEBOUNCE_CYCLES - stable cycles to accept a level change (4 .. 2^24-1)
//   REPEAT_CYCLES   - autorepeat period, >= 2 (BUTTON_AUTOREPEAT_EN only)
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   access_button_raw        - access key, active-low, asynchronous
//   reel_button_raw          - reel key, active-low, asynchronous
//   game_start_button_raw    - game start key, active-low, asynchronous
//   access_button_pulse      - registered press pulse for the access key
//   reel_button_pulse        - registered press pulse for the reel key
//   game_start_button_pulse  - registered press pulse for the game start key
// Optional feature macro: BUTTON_AUTOREPEAT_EN (autorepeat while held).
module button_shaper
  import button_shaper_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic access_button_raw,
  input  logic reel_button_raw,
  input  logic game_start_button_raw,
  output logic access_button_pulse,
  output logic reel_button_pulse,
  output logic game_start_button_pulse
);

  button_shaper_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_access (
    .clk  (clk),
    .rst  (rst),
    .raw  (access_button_raw),
    .pulse(access_button_pulse)
  );

  button_shaper_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_reel (
    .clk  (clk),
    .rst  (rst),
    .raw  (reel_button_raw),
    .pulse(reel_button_pulse)
  );

  button_shaper_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_game_start (
    .clk  (clk),
    .rst  (rst),
    .raw  (game_start_button_raw),
    .pulse(game_start_button_pulse)
  );

endmodule

// File: tb/tb_button_shaper.sv
// Testbench for button_shaper (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10).
// A run-length reference model predicts the edge after which each pulse
// appears and queues it; a monitor on the falling edge pops and compares.
// Build with BUTTON_AUTOREPEAT_EN defined to also predict repeat pulses.
module tb_button_shaper;
  import button_shaper_pkg::*;

  localparam int DB  = 4;
  localparam int RPT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] raw = 3'b111;   // [0]=access, [1]=reel, [2]=game_start
  logic [2:0] pulses;

  int n_checks = 0;
  int n_fail   = 0;

  button_shaper #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .access_button_raw      (raw[0]),
    .reel_button_raw        (raw[1]),
    .game_start_button_raw  (raw[2]),
    .access_button_pulse    (pulses[0]),
    .reel_button_pulse      (pulses[1]),
    .game_start_button_pulse(pulses[2])
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
    end
  endtask

  // Reference model state. A key is seen two edges after it is sampled; the
  // accepted level flips once the seen level has differed from it for DB+1
  // consecutive edges, and a flip to pressed yields a pulse.
  int   edge_count = 0;
  bit   last_rst   = 1'b1;
  bit   seen_d0 [3];
  bit   seen_d1 [3];
  bit   acc_pressed [3];
  int   run   [3];
  bit   armed [3];
  int   since [3];
  int   exp_q [3][$];
  int   last_pulse_edge [3];
  int   pulse_count [3];
  bit   prev_pulse [3];

  // Reference model, advanced once per rising edge.
  always @(posedge clk) begin
    edge_count++;
    last_rst = rst;
    for (int ch = 0; ch < 3; ch++) begin
      if (rst) begin
        seen_d0[ch]     = 1'b1;
        seen_d1[ch]     = 1'b1;
        acc_pressed[ch] = 1'b1;
        run[ch]         = 0;
        armed[ch]       = 1'b0;
        since[ch]       = 0;
      end else begin
        bit p;
        p = !seen_d1[ch];
        if (p != acc_pressed[ch]) begin
          run[ch]++;
          armed[ch] = 1'b0;
          if (run[ch] == DB + 1) begin
            acc_pressed[ch] = p;
            run[ch] = 0;
            if (p) begin
              exp_q[ch].push_back(edge_count);
              armed[ch] = 1'b1;
              since[ch] = 0;
            end
          end
        end else begin
          run[ch] = 0;
`ifdef BUTTON_AUTOREPEAT_EN
          if (acc_pressed[ch] && armed[ch]) begin
            since[ch]++;
            if (since[ch] == RPT) begin
              exp_q[ch].push_back(edge_count);
              since[ch] = 0;
            end
          end
`endif
        end
        seen_d1[ch] = seen_d0[ch];
        seen_d0[ch] = raw[ch];
      end
    end
  end

  // Monitor: on the falling edge compare each pulse against the queue head.
  always @(negedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      bit expected;
      expected = (exp_q[ch].size() > 0) && (exp_q[ch][0] == edge_count);
      if (last_rst) checkOutput($sformatf("reset_pulse_ch%0d", ch), int'(pulses[ch]), 0);
      if (pulses[ch] || expected) begin
        checkOutput($sformatf("pulse_ch%0d_edge%0d", ch, edge_count), int'(pulses[ch]), int'(expected));
        if (expected) void'(exp_q[ch].pop_front());
      end
      if (pulses[ch]) begin
        checkOutput($sformatf("back_to_back_ch%0d", ch), int'(prev_pulse[ch]), 0);
        last_pulse_edge[ch] = edge_count;
        pulse_count[ch]++;
      end
      while (exp_q[ch].size() > 0 && exp_q[ch][0] < edge_count) void'(exp_q[ch].pop_front());
      prev_pulse[ch] = pulses[ch];
    end
  end

  // Drive all three raw keys, then hold them for the given number of cycles.
  task automatic applyStimulus(input bit a, input bit r, input bit g, input int cycles);
    raw = {g, r, a};
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Main stimulus sequence.
  initial begin
    int start;
    int cnt0;
    for (int ch = 0; ch < 3; ch++) begin
      last_pulse_edge[ch] = -1;
      pulse_count[ch]     = 0;
      prev_pulse[ch]      = 1'b0;
    end

    doReset(3);
    applyStimulus(1, 1, 1, 10);

    // Single access press: pulse exactly DB+2 edges after the first low sample.
    start = edge_count + 1;
    applyStimulus(0, 1, 1, 30);
    checkOutput("access_latency", last_pulse_edge[0], start + 2 + DB);
    applyStimulus(1, 1, 1, 10);

    // Short reel glitch: no pulse and the FSM ends in IDLE.
    cnt0 = pulse_count[1];
    applyStimulus(1, 0, 1, 3);
    applyStimulus(1, 1, 1, 10);
    checkOutput("reel_glitch_pulses", pulse_count[1] - cnt0, 0);
    checkOutput("reel_state_idle", int'(dut.u_reel.state), int'(IDLE));

    // All three keys at once: all pulses land on the same edge.
    start = edge_count + 1;
    applyStimulus(0, 0, 0, 12);
    checkOutput("simul_access", last_pulse_edge[0], start + 2 + DB);
    checkOutput("simul_reel", last_pulse_edge[1], start + 2 + DB);
    checkOutput("simul_game", last_pulse_edge[2], start + 2 + DB);
    applyStimulus(1, 1, 1, 10);

    // Game start: short release is absorbed, long release allows a new press.
    cnt0 = pulse_count[2];
    applyStimulus(1, 1, 0, 10);
    applyStimulus(1, 1, 1, 2);
    applyStimulus(1, 1, 0, 8);
    checkOutput("game_bounce_pulses", pulse_count[2] - cnt0, 1);
    applyStimulus(1, 1, 1, 6);
    start = edge_count + 1;
    applyStimulus(1, 1, 0, 10);
    checkOutput("game_second_pulse", last_pulse_edge[2], start + 2 + DB);
    checkOutput("game_total_pulses", pulse_count[2] - cnt0, 2);
    applyStimulus(1, 1, 1, 10);

    // Access held through reset: no pulse until release and a fresh press.
    applyStimulus(0, 1, 1, 10);
    cnt0 = pulse_count[0];
    doReset(3);
    applyStimulus(0, 1, 1, 12);
    checkOutput("held_through_reset", pulse_count[0] - cnt0, 0);
    applyStimulus(1, 1, 1, 6);
    applyStimulus(0, 1, 1, 10);
    checkOutput("after_reset_press", pulse_count[0] - cnt0, 1);
    applyStimulus(1, 1, 1, 10);

    // Reset in the middle of a press debounce aborts it.
    cnt0 = pulse_count[1];
    applyStimulus(1, 0, 1, 4);
    doReset(2);
    applyStimulus(1, 1, 1, 10);
    checkOutput("reset_mid_debounce", pulse_count[1] - cnt0, 0);

    // Long reel hold: one pulse, or repeats when autorepeat is built in.
    applyStimulus(1, 0, 1, 52);
    applyStimulus(1, 1, 1, 10);

    // Random bouncing on all channels with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] nxt;
      nxt = raw;
      for (int ch = 0; ch < 3; ch++)
        if ($urandom_range(0, 5) == 0) nxt[ch] = ~nxt[ch];
      if ($urandom_range(0, 199) == 0) doReset(2);
      applyStimulus(nxt[0], nxt[1], nxt[2], 1);
    end

    applyStimulus(1, 1, 1, 20);
    for (int ch = 0; ch < 3; ch++)
      checkOutput($sformatf("pending_ch%0d", ch), exp_q[ch].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
